// File: rtl/acc_mov_serializer.sv
// acc_mov_serializer
//   Snapshots the NU_COUNT MAC accumulators into a holding bank, and on an
//   ACCMOV start copies that bank into an active bank. The active bank is then
//   streamed into XY memory at consecutive addresses. Each element goes through
//   the activation stage (ReLU/bypass, mask). It can optionally be combined with
//   the existing memory word (loopback add/sub).
//
//   Optional feature macro: ACC_MOV_SATURATE_EN
//     defined   -> loopback add/sub saturates to the Q_SIZE signed range
//     undefined -> loopback add/sub wraps modulo 2^Q_SIZE
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   serializer_update   : capture mac_reg into the holding bank
//   mac_reg             : packed accumulators, element 0 in the LSBs
//   start               : ACCMOV issue pulse (accepted only while idle)
//   y_addr, mov_length  : first write address, requested element count
//   act_bypass/act_mask : activation select (1 = identity) / force zero
//   xy_acc_loopback/op  : combine with memory (op 0 = mem+act, 1 = mem-act)
//   xy_rd_en/addr/data  : loopback read port. xy_rd_data is sampled on the
//                         clock edge that ends the cycle in which xy_rd_en is high.
//   xy_wr_en/write_addr/wr_data : write port
//   busy, done          : operation in progress / one-cycle completion pulse
module acc_mov_serializer #(
  parameter int NU_COUNT     = 4,
  parameter int Q_SIZE       = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int LENGTH_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         serializer_update,
  input  logic [NU_COUNT*Q_SIZE-1:0]   mac_reg,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        y_addr,
  input  logic [LENGTH_DEPTH-1:0]      mov_length,
  input  logic                         act_bypass,
  input  logic                         act_mask,
  input  logic                         xy_acc_loopback,
  input  logic                         xy_acc_op,
  output logic                         xy_rd_en,
  output logic [ADDR_WIDTH-1:0]        xy_rd_addr,
  input  logic [Q_SIZE-1:0]            xy_rd_data,
  output logic                         xy_wr_en,
  output logic [ADDR_WIDTH-1:0]        xy_write_addr,
  output logic [Q_SIZE-1:0]            xy_wr_data,
  output logic                         busy,
  output logic                         done
);

  localparam int IDXW = $clog2(NU_COUNT + 1);
  localparam int SELW = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef logic [NU_COUNT-1:0][Q_SIZE-1:0] bank_t;

  state_t                state, state_d;
  bank_t                 holding, holding_d, active, active_d;
  logic [IDXW-1:0]       idx, idx_d, len_q, len_d, eff_len;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  bypass_q, bypass_d, mask_q, mask_d;
  logic                  loop_q, loop_d, op_q, op_d;
  // Loopback element waiting for its read data (one cycle behind the read)
  logic                  pend_vld, pend_vld_d;
  logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_d;
  logic [Q_SIZE-1:0]     pend_act, pend_act_d;
  logic                  wr_en_d, rd_en_d, busy_d, done_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d, rd_addr_d;
  logic [Q_SIZE-1:0]     wr_data_d;
  logic                  iss, iss_loop;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [Q_SIZE-1:0]     iss_act;
  logic [SELW-1:0]       sel;

  function automatic logic [Q_SIZE-1:0] act_fn(input logic [Q_SIZE-1:0] x,
                                               input logic byp, input logic msk);
    if (msk) return '0;
    if (!byp && x[Q_SIZE-1]) return '0;
    return x;
  endfunction

  // One extra bit holds the true signed result, so overflow is visible as the
  // top two bits disagreeing.
  function automatic logic [Q_SIZE-1:0] combine(input logic [Q_SIZE-1:0] m,
                                                input logic [Q_SIZE-1:0] a,
                                                input logic op);
    logic [Q_SIZE:0] s;
    if (op) s = {m[Q_SIZE-1], m} - {a[Q_SIZE-1], a};
    else    s = {m[Q_SIZE-1], m} + {a[Q_SIZE-1], a};
`ifdef ACC_MOV_SATURATE_EN
    if (s[Q_SIZE] != s[Q_SIZE-1])
      return s[Q_SIZE] ? {1'b1, {(Q_SIZE-1){1'b0}}} : {1'b0, {(Q_SIZE-1){1'b1}}};
`endif
    return s[Q_SIZE-1:0];
  endfunction

  always_comb begin
    if (int'(mov_length) > NU_COUNT) eff_len = IDXW'(NU_COUNT);
    else                             eff_len = IDXW'(mov_length);
  end

  assign sel = idx[SELW-1:0];

  always_comb begin
    state_d     = state;
    holding_d   = serializer_update ? mac_reg : holding;
    active_d    = active;
    idx_d       = idx;
    len_d       = len_q;
    base_d      = base_q;
    bypass_d    = bypass_q;
    mask_d      = mask_q;
    loop_d      = loop_q;
    op_d        = op_q;
    pend_vld_d  = 1'b0;
    pend_addr_d = pend_addr;
    pend_act_d  = pend_act;
    wr_en_d     = 1'b0;
    wr_addr_d   = xy_write_addr;
    wr_data_d   = xy_wr_data;
    rd_en_d     = 1'b0;
    rd_addr_d   = xy_rd_addr;
    busy_d      = busy;
    done_d      = 1'b0;
    iss         = 1'b0;
    iss_loop    = 1'b0;
    iss_addr    = '0;
    iss_act     = '0;

    // Complete the loopback element whose read was issued last cycle
    if (pend_vld) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pend_addr;
      wr_data_d = combine(xy_rd_data, pend_act, op_q);
    end

    case (state)
      IDLE: begin
        if (start) begin
          // active takes the pre-capture holding even if an update lands now
          active_d = holding;
          base_d   = y_addr;
          len_d    = eff_len;
          bypass_d = act_bypass;
          mask_d   = act_mask;
          loop_d   = xy_acc_loopback;
          op_d     = xy_acc_op;
          if (eff_len == '0) begin
            done_d = 1'b1;
          end else begin
            // element 0 goes out straight from holding on the accept edge
            state_d  = RUN;
            busy_d   = 1'b1;
            idx_d    = IDXW'(1);
            iss      = 1'b1;
            iss_loop = xy_acc_loopback;
            iss_addr = y_addr;
            iss_act  = act_fn(holding[0], act_bypass, act_mask);
          end
        end
      end
      RUN: begin
        if (idx == len_q) begin
          if (loop_q) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          iss      = 1'b1;
          iss_loop = loop_q;
          iss_addr = base_q + ADDR_WIDTH'(idx);
          iss_act  = act_fn(active[sel], bypass_q, mask_q);
          idx_d    = idx + IDXW'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (iss) begin
      if (iss_loop) begin
        rd_en_d     = 1'b1;
        rd_addr_d   = iss_addr;
        pend_vld_d  = 1'b1;
        pend_addr_d = iss_addr;
        pend_act_d  = iss_act;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = iss_addr;
        wr_data_d = iss_act;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      holding       <= '0;
      active        <= '0;
      idx           <= '0;
      len_q         <= '0;
      base_q        <= '0;
      bypass_q      <= 1'b0;
      mask_q        <= 1'b0;
      loop_q        <= 1'b0;
      op_q          <= 1'b0;
      pend_vld      <= 1'b0;
      pend_addr     <= '0;
      pend_act      <= '0;
      xy_wr_en      <= 1'b0;
      xy_write_addr <= '0;
      xy_wr_data    <= '0;
      xy_rd_en      <= 1'b0;
      xy_rd_addr    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      holding       <= holding_d;
      active        <= active_d;
      idx           <= idx_d;
      len_q         <= len_d;
      base_q        <= base_d;
      bypass_q      <= bypass_d;
      mask_q        <= mask_d;
      loop_q        <= loop_d;
      op_q          <= op_d;
      pend_vld      <= pend_vld_d;
      pend_addr     <= pend_addr_d;
      pend_act      <= pend_act_d;
      xy_wr_en      <= wr_en_d;
      xy_write_addr <= wr_addr_d;
      xy_wr_data    <= wr_data_d;
      xy_rd_en      <= rd_en_d;
      xy_rd_addr    <= rd_addr_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule
